// File: rtl/daq_pkg.sv
// Shared constants and state encoding for the DAQ ADC/DAC serial link models.
package daq_pkg;

    localparam int DATA_W      = 12;
    localparam int LEAD_ZEROS  = 4;
    localparam int SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        WAIT_CS = 2'd2
    } resp_state_t;

endpackage

// File: rtl/spi_edge_sync.sv
// Synchronises one asynchronous SPI pin into clk and produces single-cycle
// rise/fall pulses from the synchronised level and a history flop.
module spi_edge_sync
    import daq_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall,
    output logic valid
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic [SYNC_STAGES:0]   prime_q;

    // prime_q fills with ones after reset so the artificial reset value of the
    // synchroniser never masquerades as a real pin level or edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '1;
            hist_q  <= 1'b1;
            prime_q <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], pin};
            hist_q  <= sync_q[SYNC_STAGES-1];
            prime_q <= {prime_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign valid = prime_q[SYNC_STAGES];
    assign rise  = valid &  level & ~hist_q;
    assign fall  = valid & ~level &  hist_q;

endmodule

// File: rtl/spi_adc_responder.sv
// SPI mode-0 slave emulating the serial ADC: shifts a held sample out on MISO,
// MSB-first after a run of leading zeros, entirely in the clk domain.
module spi_adc_responder #(
    parameter int DATA_W     = daq_pkg::DATA_W,
    parameter int LEAD_ZEROS = daq_pkg::LEAD_ZEROS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs_n,
    input  logic              sclk,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              sample_taken,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_err
);

    import daq_pkg::*;

    localparam int FRAME_BITS = LEAD_ZEROS + DATA_W;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS);

    logic                  cs_level, cs_rise, cs_fall, cs_valid;
    logic                  sclk_level, sclk_rise, sclk_fall, sclk_valid;
    logic                  unused_sclk;
    logic [DATA_W-1:0]     hold;
    logic [FRAME_BITS-1:0] shift;
    logic [FRAME_BITS-1:0] load_word;
    logic [CNT_W-1:0]      bit_cnt;
    logic [CNT_W-1:0]      next_cnt;
    logic                  armed;
    resp_state_t           state;

    spi_edge_sync u_cs_sync (
        .clk   (clk),
        .reset (reset),
        .pin   (cs_n),
        .level (cs_level),
        .rise  (cs_rise),
        .fall  (cs_fall),
        .valid (cs_valid)
    );

    spi_edge_sync u_sclk_sync (
        .clk   (clk),
        .reset (reset),
        .pin   (sclk),
        .level (sclk_level),
        .rise  (sclk_rise),
        .fall  (sclk_fall),
        .valid (sclk_valid)
    );

    assign unused_sclk = sclk_level ^ sclk_valid;

    // A sample arriving on the very cycle the frame starts is used directly.
    assign load_word = {{LEAD_ZEROS{1'b0}}, (din_valid ? din : hold)};
    assign next_cnt  = bit_cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            miso         <= 1'b0;
            miso_oe      <= 1'b0;
            busy         <= 1'b0;
            sample_taken <= 1'b0;
            frame_done   <= 1'b0;
            frame_err    <= 1'b0;
            hold         <= '0;
            shift        <= '0;
            bit_cnt      <= '0;
            armed        <= 1'b0;
            state        <= IDLE;
        end else begin
            sample_taken <= 1'b0;
            frame_done   <= 1'b0;
            frame_err    <= 1'b0;

            if (din_valid)
                hold <= din;

            // A chip select already low when reset lifts must be released first.
            if (cs_valid && cs_level)
                armed <= 1'b1;

            case (state)
                IDLE: begin
                    miso    <= 1'b0;
                    miso_oe <= 1'b0;
                    busy    <= 1'b0;
                    if (cs_fall && armed) begin
                        shift        <= load_word;
                        sample_taken <= 1'b1;
                        bit_cnt      <= '0;
                        miso         <= load_word[FRAME_BITS-1];
                        miso_oe      <= 1'b1;
                        busy         <= 1'b1;
                        state        <= ACTIVE;
                    end
                end

                ACTIVE: begin
                    if (sclk_rise)
                        bit_cnt <= next_cnt;

                    if (sclk_rise && (next_cnt == LAST_CNT)) begin
                        frame_done <= 1'b1;
                        miso       <= 1'b0;
                        if (cs_rise) begin
                            miso_oe <= 1'b0;
                            busy    <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            state   <= WAIT_CS;
                        end
                    end else if (cs_rise) begin
                        frame_err <= 1'b1;
                        miso      <= 1'b0;
                        miso_oe   <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (sclk_fall && (bit_cnt < LAST_CNT)) begin
                        shift <= {shift[FRAME_BITS-2:0], 1'b0};
                        miso  <= shift[FRAME_BITS-2];
                    end
                end

                WAIT_CS: begin
                    miso    <= 1'b0;
                    miso_oe <= 1'b1;
                    busy    <= 1'b1;
                    if (cs_rise) begin
                        miso_oe <= 1'b0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
